seven_seg_scanner: RTL

- Multiplexed seven-segment driver for the parking-lot occupancy/fee display.
- Sits directly downstream of the clock divider: it consumes that block's `clk_500Hz` square wave as its digit-scan rate and `clk_2Hz` as its blink rate.
- Both are sampled in the system clock domain; the block never clocks logic on them.
- Display data is double-buffered and swapped only at frame boundaries, so a digit is never torn mid-frame.

---
 rtl/seven_seg_scanner.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner
//   Multiplexed seven-segment driver for the parking-lot occupancy/fee
//   display. Scan and blink rates come in as square waves from the clock
//   divider and are sampled in the clk domain; no logic is clocked by them.
//   Display data is double-buffered and swapped only at frame boundaries.
//
// Ports
//   clk          system clock
//   reset        asynchronous active-high reset
//   scan_clk     500 Hz square wave, one digit step per rising edge
//   blink_clk    2 Hz square wave, blink phase
//   digits       BCD per digit, digit k in [4k+3:4k]
//   dp           decimal point per digit
//   blink_mask   per-digit blink enable
//   update       one-cycle strobe capturing digits/dp/blink_mask
//   seg          segments {g,f,e,d,c,b,a}
//   seg_dp       decimal point segment
//   an           one-hot digit enable
//   frame_start  one-cycle pulse when digit 0 begins
//
// Configuration
//   SEVEN_SEG_BLINK_EN  when defined, masked digits have their anode held
//                       off while the synchronised blink phase is low.
//                       When undefined, blink_clk and blink_mask are ignored.

module seven_seg_scanner #(
    parameter int NUM_DIGITS     = 4,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    scan_clk,
    input  logic                    blink_clk,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    update,
    output logic [6:0]              seg,
    output logic                    seg_dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_start
);

    localparam int                    IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IW-1:0]         LAST    = IW'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF  = (SEG_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? '1 : '0;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] s;
        case (bcd)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // ---------------- input synchronisation ----------------
    logic scan_s1, scan_s2, scan_s3;
    logic scan_tick;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_s1 <= 1'b0;
            scan_s2 <= 1'b0;
            scan_s3 <= 1'b0;
        end else begin
            scan_s1 <= scan_clk;
            scan_s2 <= scan_s1;
            scan_s3 <= scan_s2;
        end
    end

    assign scan_tick = scan_s2 & ~scan_s3;

    // ---------------- digit index ----------------
    logic [IW-1:0] idx;
    logic          wrap_now;

    assign wrap_now = scan_tick && (idx == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx <= LAST;
        end else if (scan_tick) begin
            idx <= (idx == LAST) ? '0 : idx + 1'b1;
        end
    end

    // ---------------- double buffer ----------------
    logic [4*NUM_DIGITS-1:0] stage_digits, shadow_digits;
    logic [NUM_DIGITS-1:0]   stage_dp, shadow_dp;
    logic                    pending;

    // An update landing on the wrap edge goes straight to the shadow so the
    // frame that is just starting already shows it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_digits  <= '0;
            stage_dp      <= '0;
            shadow_digits <= '0;
            shadow_dp     <= '0;
            pending       <= 1'b0;
        end else if (update && wrap_now) begin
            stage_digits  <= digits;
            stage_dp      <= dp;
            shadow_digits <= digits;
            shadow_dp     <= dp;
            pending       <= 1'b0;
        end else if (update) begin
            stage_digits  <= digits;
            stage_dp      <= dp;
            pending       <= 1'b1;
        end else if (wrap_now && pending) begin
            shadow_digits <= stage_digits;
            shadow_dp     <= stage_dp;
            pending       <= 1'b0;
        end
    end

    // ---------------- current digit select ----------------
    logic [3:0]            cur_bcd;
    logic                  cur_dp;
    logic [NUM_DIGITS-1:0] cur_onehot;
    logic                  hide;

`ifdef SEVEN_SEG_BLINK_EN
    logic                  blink_s1, blink_s;
    logic [NUM_DIGITS-1:0] stage_blink, shadow_blink;
    logic                  cur_blink;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_s1 <= 1'b0;
            blink_s  <= 1'b0;
        end else begin
            blink_s1 <= blink_clk;
            blink_s  <= blink_s1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_blink  <= '0;
            shadow_blink <= '0;
        end else if (update && wrap_now) begin
            stage_blink  <= blink_mask;
            shadow_blink <= blink_mask;
        end else if (update) begin
            stage_blink  <= blink_mask;
        end else if (wrap_now && pending) begin
            shadow_blink <= stage_blink;
        end
    end

    always_comb begin
        cur_blink = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IW'(k)) cur_blink = shadow_blink[k];
        end
    end

    assign hide = cur_blink & ~blink_s;
`else
    logic unused_blink;
    assign unused_blink = ^{blink_clk, blink_mask};
    assign hide = 1'b0;
`endif

    always_comb begin
        cur_bcd    = '0;
        cur_dp     = 1'b0;
        cur_onehot = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IW'(k)) begin
                cur_bcd       = shadow_digits[4*k +: 4];
                cur_dp        = shadow_dp[k];
                cur_onehot[k] = 1'b1;
            end
        end
    end

    // ---------------- anti-ghost and output registers ----------------
    // blank is high for the one cycle after a tick, so the anodes stay off
    // while seg switches to the new digit. armed keeps the anodes off after
    // reset until the first tick has selected digit 0.
    logic blank, wrap_q, armed;
    logic [6:0] dec;

    assign dec = bcd_to_seg(cur_bcd);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blank  <= 1'b0;
            wrap_q <= 1'b0;
            armed  <= 1'b0;
        end else begin
            blank  <= scan_tick;
            wrap_q <= wrap_now;
            if (scan_tick) armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg         <= SEG_OFF;
            seg_dp      <= DP_OFF;
            an          <= AN_OFF;
            frame_start <= 1'b0;
        end else begin
            seg         <= (SEG_ACTIVE_LOW != 0) ? ~dec : dec;
            seg_dp      <= (SEG_ACTIVE_LOW != 0) ? ~cur_dp : cur_dp;
            if (blank || !armed || hide)
                an <= AN_OFF;
            else
                an <= (AN_ACTIVE_LOW != 0) ? ~cur_onehot : cur_onehot;
            frame_start <= wrap_q;
        end
    end

endmodule
